// File: rtl/reorder_buffer.sv
// ============================================================================
// reorder_buffer
// ----------------------------------------------------------------------------
// In-order retirement buffer sitting directly behind the rename stage.
// Renamed instructions are written at the tail (one per cycle). Writeback
// marks entries done and may flag an exception. The oldest entry retires
// in program order, and its p_old is returned to the free list. An excepting
// head does not retire. Instead the whole buffer is flushed and the rename
// stage receives the PC and rename-history pointer it needs for recovery.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   alloc_*           : allocation handshake and payload from rename;
//                       alloc_rob_idx is the slot the allocating entry gets
//   wb_*              : completion from execution (index + exception flag)
//   commit_*          : head retirement (architectural map + free list)
//   flush_*           : one-cycle recovery pulse; pc/hist_ptr hold afterwards
//   count, empty      : occupancy
// ============================================================================
module reorder_buffer #(
    parameter int ROB_SIZE  = 16,
    parameter int PRN_WIDTH = 6,
    parameter int ARN_WIDTH = 5,
    parameter int PC_SIZE   = 64,
    parameter int HISTW     = 5,
    localparam int IDXW     = $clog2(ROB_SIZE),
    localparam int PTRW     = IDXW + 1,
    localparam int CNTW     = $clog2(ROB_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic                 alloc_writes_rd,
    input  logic [ARN_WIDTH-1:0] alloc_rd_arch,
    input  logic [PRN_WIDTH-1:0] alloc_p_new,
    input  logic [PRN_WIDTH-1:0] alloc_p_old,
    input  logic [HISTW-1:0]     alloc_hist_ptr,
    input  logic [PC_SIZE-1:0]   alloc_pc,
    output logic [IDXW-1:0]      alloc_rob_idx,

    input  logic                 wb_valid,
    input  logic [IDXW-1:0]      wb_rob_idx,
    input  logic                 wb_exception,

    output logic                 commit_valid,
    output logic                 commit_writes_rd,
    output logic [ARN_WIDTH-1:0] commit_rd_arch,
    output logic [PRN_WIDTH-1:0] commit_p_new,
    output logic [PRN_WIDTH-1:0] commit_p_old,

    output logic                 flush_valid,
    output logic [PC_SIZE-1:0]   flush_pc,
    output logic [HISTW-1:0]     flush_hist_ptr,

    output logic [CNTW-1:0]      count,
    output logic                 empty
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } robState_e;

    robState_e state_q, state_d;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTRW-1:0] headPtr_q, tailPtr_q;

    logic [ROB_SIZE-1:0] valid_q;
    logic [ROB_SIZE-1:0] done_q;
    logic [ROB_SIZE-1:0] exc_q;
    logic [ROB_SIZE-1:0] writesRd_q;

    logic [PRN_WIDTH-1:0] pNew_q   [ROB_SIZE];
    logic [PRN_WIDTH-1:0] pOld_q   [ROB_SIZE];
    logic [ARN_WIDTH-1:0] rdArch_q [ROB_SIZE];
    logic [HISTW-1:0]     hist_q   [ROB_SIZE];
    logic [PC_SIZE-1:0]   pc_q     [ROB_SIZE];

    logic [PC_SIZE-1:0] flushPc_q;
    logic [HISTW-1:0]   flushHist_q;

    logic [IDXW-1:0] headIdx, tailIdx;
    logic            full;
    logic            headExcFire;
    logic            allocFire;
    logic            commitFire;

    assign headIdx = headPtr_q[IDXW-1:0];
    assign tailIdx = tailPtr_q[IDXW-1:0];
    assign full    = (headIdx == tailIdx) && (headPtr_q[IDXW] != tailPtr_q[IDXW]);
    assign empty   = (headPtr_q == tailPtr_q);
    assign count   = CNTW'(tailPtr_q - headPtr_q);

    // The head is done with an exception. Nothing retires, and the next edge flushes.
    assign headExcFire = (state_q == RUN) && valid_q[headIdx] && done_q[headIdx] && exc_q[headIdx];

    assign allocFire  = alloc_valid && alloc_ready;
    assign commitFire = commit_valid;

    assign alloc_rob_idx    = tailIdx;
    assign commit_writes_rd = writesRd_q[headIdx];
    assign commit_rd_arch   = rdArch_q[headIdx];
    assign commit_p_new     = pNew_q[headIdx];
    assign commit_p_old     = pOld_q[headIdx];
    assign flush_pc         = flushPc_q;
    assign flush_hist_ptr   = flushHist_q;

    // State register. FLUSH always lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. Allocation is held off while full, while
    // an exception is waiting at the head, and during the flush cycle. It has no
    // same-cycle bypass from a commit. Commit is gated by reset so that nothing
    // is pushed to the free list during a reset cycle.
    always_comb begin
        state_d      = state_q;
        alloc_ready  = 1'b0;
        commit_valid = 1'b0;
        flush_valid  = 1'b0;
        case (state_q)
            RUN: begin
                alloc_ready  = !rst && !full && !headExcFire;
                commit_valid = !rst && valid_q[headIdx] && done_q[headIdx] && !exc_q[headIdx];
                if (headExcFire) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_valid = 1'b1;
                state_d     = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Control state: pointers, status bits and captured flush info. A flush
    // wins over writeback, commit and allocation in the same cycle. Writeback
    // only lands on live entries, so late completions after a flush are dropped.
    // An allocated tail slot is never live, and a commit clears the head
    // while a duplicate writeback may touch it. Neither case collides.
    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr_q   <= '0;
            tailPtr_q   <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            exc_q       <= '0;
            flushPc_q   <= '0;
            flushHist_q <= '0;
        end else if (headExcFire) begin
            flushPc_q   <= pc_q[headIdx];
            flushHist_q <= hist_q[headIdx];
            headPtr_q   <= '0;
            tailPtr_q   <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            exc_q       <= '0;
        end else begin
            if (wb_valid && valid_q[wb_rob_idx]) begin
                done_q[wb_rob_idx] <= 1'b1;
                exc_q[wb_rob_idx]  <= wb_exception;
            end
            if (commitFire) begin
                valid_q[headIdx] <= 1'b0;
                headPtr_q        <= headPtr_q + 1'b1;
            end
            if (allocFire) begin
                valid_q[tailIdx] <= 1'b1;
                done_q[tailIdx]  <= 1'b0;
                exc_q[tailIdx]   <= 1'b0;
                tailPtr_q        <= tailPtr_q + 1'b1;
            end
        end
    end

    // Payload storage. It needs no reset because the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (allocFire) begin
            writesRd_q[tailIdx] <= alloc_writes_rd;
            pNew_q[tailIdx]     <= alloc_p_new;
            pOld_q[tailIdx]     <= alloc_p_old;
            rdArch_q[tailIdx]   <= alloc_rd_arch;
            hist_q[tailIdx]     <= alloc_hist_ptr;
            pc_q[tailIdx]       <= alloc_pc;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// tb_reorder_buffer
// ----------------------------------------------------------------------------
// Directed bench for reorder_buffer. Each accepted allocation pushes its
// expected commit fields into a scoreboard queue. Whenever the buffer
// presents a commit, the front of the queue is popped and compared.
// ============================================================================
module tb_reorder_buffer;

    localparam int ROB_SIZE = 16;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_writes_rd;
    logic [4:0]  alloc_rd_arch;
    logic [5:0]  alloc_p_new;
    logic [5:0]  alloc_p_old;
    logic [4:0]  alloc_hist_ptr;
    logic [63:0] alloc_pc;
    logic [3:0]  alloc_rob_idx;
    logic        wb_valid;
    logic [3:0]  wb_rob_idx;
    logic        wb_exception;
    logic        commit_valid;
    logic        commit_writes_rd;
    logic [4:0]  commit_rd_arch;
    logic [5:0]  commit_p_new;
    logic [5:0]  commit_p_old;
    logic        flush_valid;
    logic [63:0] flush_pc;
    logic [4:0]  flush_hist_ptr;
    logic [4:0]  count;
    logic        empty;

    typedef struct {
        logic [5:0] pOld;
        logic [5:0] pNew;
        logic [4:0] rd;
        logic       wr;
    } expCommit_t;

    expCommit_t sbq[$];
    int errors = 0;
    int checks = 0;
    int modelTail = 0;

    reorder_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_writes_rd  (alloc_writes_rd),
        .alloc_rd_arch    (alloc_rd_arch),
        .alloc_p_new      (alloc_p_new),
        .alloc_p_old      (alloc_p_old),
        .alloc_hist_ptr   (alloc_hist_ptr),
        .alloc_pc         (alloc_pc),
        .alloc_rob_idx    (alloc_rob_idx),
        .wb_valid         (wb_valid),
        .wb_rob_idx       (wb_rob_idx),
        .wb_exception     (wb_exception),
        .commit_valid     (commit_valid),
        .commit_writes_rd (commit_writes_rd),
        .commit_rd_arch   (commit_rd_arch),
        .commit_p_new     (commit_p_new),
        .commit_p_old     (commit_p_old),
        .flush_valid      (flush_valid),
        .flush_pc         (flush_pc),
        .flush_hist_ptr   (flush_hist_ptr),
        .count            (count),
        .empty            (empty)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge. Before the rising edge,
    // this task scores any commit being presented and records any allocation
    // that will be accepted. It returns at the next falling edge.
    task automatic applyStimulus(input logic av, input logic [5:0] pOld, input logic [63:0] pc,
                                 input logic [4:0] hist, input logic wbv, input logic [3:0] wbIdx,
                                 input logic wbExc);
        expCommit_t e;
        alloc_valid     = av;
        alloc_p_old     = pOld;
        alloc_p_new     = pOld + 6'd16;
        alloc_rd_arch   = pOld[4:0] + 5'd1;
        alloc_writes_rd = pOld[0];
        alloc_hist_ptr  = hist;
        alloc_pc        = pc;
        wb_valid        = wbv;
        wb_rob_idx      = wbIdx;
        wb_exception    = wbExc;
        #1;
        if (commit_valid) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpectedCommit", 64'(commit_p_old), 64'h3f);
            end else begin
                e = sbq.pop_front();
                checkOutput("commitPOld", 64'(commit_p_old), 64'(e.pOld));
                checkOutput("commitPNew", 64'(commit_p_new), 64'(e.pNew));
                checkOutput("commitRd", 64'(commit_rd_arch), 64'(e.rd));
                checkOutput("commitWr", 64'(commit_writes_rd), 64'(e.wr));
            end
        end
        if (av && alloc_ready) begin
            checkOutput("allocIdx", 64'(alloc_rob_idx), 64'(modelTail % ROB_SIZE));
            modelTail++;
            e.pOld = pOld;
            e.pNew = pOld + 6'd16;
            e.rd   = pOld[4:0] + 5'd1;
            e.wr   = pOld[0];
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        alloc_valid = 1'b0;
        wb_valid = 1'b0;
        @(negedge clk);
        checkOutput("allocReadyInReset", 64'(alloc_ready), 64'd0);
        rst = 1'b0;
        sbq.delete();
        modelTail = 0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_writes_rd = 1'b0; alloc_rd_arch = '0; alloc_p_new = '0;
        alloc_p_old = '0; alloc_hist_ptr = '0; alloc_pc = '0;
        wb_valid = 1'b0; wb_rob_idx = '0; wb_exception = 1'b0;

        // ---- reset state ----
        doReset();
        checkOutput("rstCount", 64'(count), 64'd0);
        checkOutput("rstEmpty", 64'(empty), 64'd1);
        checkOutput("rstCommit", 64'(commit_valid), 64'd0);
        checkOutput("rstFlush", 64'(flush_valid), 64'd0);
        checkOutput("rstFlushPc", flush_pc, 64'd0);
        checkOutput("rstFlushHist", 64'(flush_hist_ptr), 64'd0);
        checkOutput("rstAllocIdx", 64'(alloc_rob_idx), 64'd0);
        checkOutput("rstAllocReady", 64'(alloc_ready), 64'd1);

        // ---- in-order commit with out-of-order writeback ----
        applyStimulus(1'b1, 6'd33, 64'h100, 5'd1, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 6'd34, 64'h104, 5'd2, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 6'd35, 64'h108, 5'd3, 1'b0, 4'd0, 1'b0);
        checkOutput("s1Count3", 64'(count), 64'd3);
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd1, 1'b0);
        checkOutput("s1NoCommitBeforeHead", 64'(commit_valid), 64'd0);
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd0, 1'b0);
        checkOutput("s1CommitAfterWb", 64'(commit_valid), 64'd1);
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd2, 1'b0);
        checkOutput("s1SecondCommit", 64'(commit_valid), 64'd1);
        idle();
        idle();
        checkOutput("s1CountZero", 64'(count), 64'd0);
        checkOutput("s1Empty", 64'(empty), 64'd1);
        checkOutput("s1Drained", 64'(sbq.size()), 64'd0);
        checkOutput("s1Idle", 64'(commit_valid), 64'd0);

        // ---- full buffer, commit then re-allocate with wrap ----
        doReset();
        for (int i = 0; i < ROB_SIZE; i++) begin
            applyStimulus(1'b1, 6'(i), 64'(i * 4), 5'(i), 1'b0, 4'd0, 1'b0);
        end
        checkOutput("s2Count16", 64'(count), 64'd16);
        checkOutput("s2FullNotReady", 64'(alloc_ready), 64'd0);
        checkOutput("s2NotEmpty", 64'(empty), 64'd0);
        applyStimulus(1'b1, 6'd40, 64'h400, 5'd0, 1'b1, 4'd0, 1'b0);
        checkOutput("s2CommitReady", 64'(commit_valid), 64'd1);
        checkOutput("s2NoBypass", 64'(alloc_ready), 64'd0);
        checkOutput("s2Count16b", 64'(count), 64'd16);
        applyStimulus(1'b1, 6'd41, 64'h404, 5'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("s2Count15", 64'(count), 64'd15);
        checkOutput("s2ReadyAfterCommit", 64'(alloc_ready), 64'd1);
        checkOutput("s2WrapIdx", 64'(alloc_rob_idx), 64'd0);
        applyStimulus(1'b1, 6'd42, 64'h408, 5'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("s2Count16c", 64'(count), 64'd16);
        checkOutput("s2FullAgain", 64'(alloc_ready), 64'd0);
        checkOutput("s2Queue", 64'(sbq.size()), 64'd16);

        // ---- exception at entry 2 flushes the buffer ----
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 6'(50 + i), 64'(64'h200 + 64'(i * 4)), 5'(10 + i), 1'b0, 4'd0, 1'b0);
        end
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd2, 1'b1);
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd1, 1'b0);
        checkOutput("s3Commit1", 64'(commit_valid), 64'd1);
        idle();
        checkOutput("s3ExcNoCommit", 64'(commit_valid), 64'd0);
        checkOutput("s3ExcBlocksAlloc", 64'(alloc_ready), 64'd0);
        checkOutput("s3NoFlushYet", 64'(flush_valid), 64'd0);
        checkOutput("s3Drained2", 64'(sbq.size()), 64'd2);
        applyStimulus(1'b1, 6'd7, 64'h999, 5'd7, 1'b0, 4'd0, 1'b0);
        checkOutput("s3FlushValid", 64'(flush_valid), 64'd1);
        checkOutput("s3FlushPc", flush_pc, 64'h208);
        checkOutput("s3FlushHist", 64'(flush_hist_ptr), 64'd12);
        checkOutput("s3FlushCount", 64'(count), 64'd0);
        checkOutput("s3FlushEmpty", 64'(empty), 64'd1);
        checkOutput("s3FlushNoAlloc", 64'(alloc_ready), 64'd0);
        checkOutput("s3FlushNoCommit", 64'(commit_valid), 64'd0);
        sbq.delete();
        modelTail = 0;
        idle();
        checkOutput("s3FlushOneCycle", 64'(flush_valid), 64'd0);
        checkOutput("s3FlushPcHold", flush_pc, 64'h208);
        checkOutput("s3ReadyAfter", 64'(alloc_ready), 64'd1);
        checkOutput("s3Idx3Gone", 64'(commit_valid), 64'd0);

        // ---- writeback to an unallocated entry ----
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd5, 1'b1);
        checkOutput("s4NoCommit", 64'(commit_valid), 64'd0);
        checkOutput("s4Count", 64'(count), 64'd0);
        idle();
        checkOutput("s4NoFlush", 64'(flush_valid), 64'd0);
        checkOutput("s4StillEmpty", 64'(empty), 64'd1);

        // ---- reset during the flush cycle ----
        applyStimulus(1'b1, 6'd60, 64'h300, 5'd20, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 6'd61, 64'h304, 5'd21, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 6'd62, 64'h308, 5'd22, 1'b1, 4'd0, 1'b1);
        idle();
        checkOutput("s5InFlush", 64'(flush_valid), 64'd1);
        checkOutput("s5FlushPc", flush_pc, 64'h300);
        doReset();
        checkOutput("s5Count", 64'(count), 64'd0);
        checkOutput("s5FlushCleared", 64'(flush_valid), 64'd0);
        checkOutput("s5FlushPcCleared", flush_pc, 64'd0);
        checkOutput("s5Ready", 64'(alloc_ready), 64'd1);

        // ---- allocate while the only entry becomes done ----
        applyStimulus(1'b1, 6'd20, 64'h500, 5'd1, 1'b0, 4'd0, 1'b0);
        checkOutput("s6Count1", 64'(count), 64'd1);
        applyStimulus(1'b1, 6'd21, 64'h504, 5'd2, 1'b1, 4'd0, 1'b0);
        checkOutput("s6CommitValid", 64'(commit_valid), 64'd1);
        checkOutput("s6Count2", 64'(count), 64'd2);
        idle();
        checkOutput("s6Count1b", 64'(count), 64'd1);
        checkOutput("s6NoCommit", 64'(commit_valid), 64'd0);
        applyStimulus(1'b0, 6'd0, 64'd0, 5'd0, 1'b1, 4'd1, 1'b0);
        idle();
        checkOutput("s6Count0", 64'(count), 64'd0);
        checkOutput("s6Drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
